// File: rtl/adder_arb_pkg.sv
// Shared types for the adder arbiter: ALU operation codes, controller states
// and the requester-index width helper.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_LT,
    ALU_LTU
  } ALUOp_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_RUN
  } adder_arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_arb_if.sv
// Requester-side bus of the adder arbiter: per-requester operation handshake
// plus the shared tagged response.
interface adder_arb_if
  import adder_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
);

  // An operation from requester i transfers in any cycle where
  // req_valid[i] & req_ready[i]; req_ready is combinational from req_valid,
  // so req_valid must never be derived from req_ready.
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  ALUOp_t           req_op [NREQ];
  logic [WIDTH-1:0] req_a  [NREQ];
  logic [WIDTH-1:0] req_b  [NREQ];
  logic [NREQ-1:0]  rsp_valid;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/adder_arb_rr.sv
// Combinational round-robin pick: rotate so last_grant+1 is bit 0, take the
// lowest set bit, rotate back. Produces a one-hot (or zero) grant.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant
);

  logic [IW:0]     shift;
  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] pick;

  // last_grant = NREQ-1 gives shift = NREQ, which is the identity rotation.
  assign shift = {1'b0, last_grant} + (IW+1)'(1);
  assign rot   = NREQ'({req, req} >> shift);
  assign pick  = rot & (~rot + NREQ'(1));
  assign grant = NREQ'(({pick, pick} << shift) >> NREQ);

endmodule

// File: rtl/adder_arb.sv
// Round-robin controller sharing one multi-cycle adder among NREQ requesters;
// latches one operation, runs the adder start/done protocol, returns a tagged pulse.
module adder_arb
  import adder_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  parameter int WADD  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  adder_arb_if.slave       bus,
  output logic             add_start,
  output ALUOp_t           add_op,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_out,
  input  logic             add_done,
  output adder_arb_state_t dbg_state
);

  localparam int IW = idx_width(NREQ);

  if (NREQ < 2 || WADD < 1 || WIDTH < 1) begin : g_bad_param
    $error("adder_arb: illegal parameters");
  end

  adder_arb_state_t state;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    grant_idx;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  ALUOp_t           op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             discard;
  logic             window;
  logic             finish;
  logic             accept;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = IW'(i);
    end
  end

  // The next accept may land in the adder's done cycle, giving back-to-back use.
  assign finish = (state == ARB_RUN) && add_done;
  assign window = rst_n && !flush && ((state == ARB_IDLE) || finish);
  assign accept = window && (|grant);

  assign bus.req_ready = window ? grant : '0;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign add_start     = (state == ARB_RUN);
  assign add_op        = op_q;
  assign add_a         = a_q;
  assign add_b         = b_q;
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      last_grant <= IW'(NREQ - 1);
      idx        <= '0;
      discard    <= 1'b0;
      op_q       <= ALU_ADD;
      a_q        <= '0;
      b_q        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
    end else begin
      rsp_valid <= '0;
      if (finish) begin
        rsp_data <= add_out;
        // A flush landing in the done cycle discards that same result.
        if (!discard && !flush) rsp_valid <= NREQ'(1) << idx;
      end
      if ((state == ARB_RUN) && flush) discard <= 1'b1;
      if (accept) begin
        state      <= ARB_RUN;
        op_q       <= bus.req_op[grant_idx];
        a_q        <= bus.req_a[grant_idx];
        b_q        <= bus.req_b[grant_idx];
        idx        <= grant_idx;
        last_grant <= grant_idx;
        discard    <= 1'b0;
      end else if (finish) begin
        state <= ARB_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_adder_arb.sv
// Bench for adder_arb: a behavioural segmented adder, a transaction-level
// scoreboard fed from observed accepts, and directed plus random stimulus.
module tb_adder_arb;
  import adder_arb_pkg::*;

  localparam int NREQ  = 2;
  localparam int WIDTH = 32;
  localparam int WADD  = 16;
  localparam int NCYC  = (WIDTH + WADD - 1) / WADD;
  localparam int EW    = NREQ + WIDTH;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic flush1 = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- DUT with two-slice adder ----------------
  adder_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
  logic             add_start, add_done;
  ALUOp_t           add_op;
  logic [WIDTH-1:0] add_a, add_b, add_out;
  adder_arb_state_t dbg_state;

  adder_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .WADD(WADD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .add_start (add_start),
    .add_op    (add_op),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_out   (add_out),
    .add_done  (add_done),
    .dbg_state (dbg_state)
  );

  int seg_cnt = 0;
  assign add_done = add_start && (seg_cnt == NCYC - 1);
  assign add_out  = (add_op == ALU_ADD) ? add_a + add_b : add_a - add_b;
  always @(posedge clk) begin
    if (!rst_n || !add_start || add_done) seg_cnt <= 0;
    else seg_cnt <= seg_cnt + 1;
  end

  // ---------------- DUT with single-slice adder ----------------
  adder_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus1 ();
  logic             add1_start, add1_done;
  ALUOp_t           add1_op;
  logic [WIDTH-1:0] add1_a, add1_b, add1_out;
  adder_arb_state_t dbg_state1;

  adder_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .WADD(WIDTH)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush1),
    .bus       (bus1),
    .add_start (add1_start),
    .add_op    (add1_op),
    .add_a     (add1_a),
    .add_b     (add1_b),
    .add_out   (add1_out),
    .add_done  (add1_done),
    .dbg_state (dbg_state1)
  );

  assign add1_done = add1_start;
  assign add1_out  = (add1_op == ALU_ADD) ? add1_a + add1_b : add1_a - add1_b;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [WIDTH-1:0] ref_result(input ALUOp_t op, input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    return (op == ALU_ADD) ? a + b : a - b;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  // Each accepted operation becomes one expected {tag, data}; it is queued when
  // the adder finishes it, unless a flush was seen while it was in flight.
  logic [EW-1:0]   exp_q[$];
  logic [EW-1:0]   pend_item;
  logic [EW-1:0]   got;
  logic [NREQ-1:0] tag;
  bit              pend = 1'b0;
  bit              pend_drop = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (bus.rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL rsp_unexpected: got tag 0x%0h data 0x%0h expected no response",
                   bus.rsp_valid, bus.rsp_data);
        end else begin
          got = exp_q.pop_front();
          chk("rsp_tag", bus.rsp_valid, got[EW-1:WIDTH]);
          chk("rsp_data", bus.rsp_data, got[WIDTH-1:0]);
        end
      end
      if (pend && flush) pend_drop = 1'b1;
      if (pend && add_done) begin
        if (!pend_drop) exp_q.push_back(pend_item);
        pend = 1'b0;
      end
      for (int r = 0; r < NREQ; r++) begin
        if (bus.req_valid[r] && bus.req_ready[r]) begin
          tag       = NREQ'(1) << r;
          pend_item = {tag, ref_result(bus.req_op[r], bus.req_a[r], bus.req_b[r])};
          pend      = 1'b1;
          pend_drop = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic single_op(input int r, input ALUOp_t op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_data);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << r;
    bus.req_op[r] = op;
    bus.req_a[r]  = a;
    bus.req_b[r]  = b;
    bus.req_valid = oh;
    #1 chk("op_ready", bus.req_ready, oh);
    cyc();
    bus.req_valid = '0;
    #1 chk("op_start_t1", add_start, 1'b1);
    chk("op_a_latched", add_a, a);
    cyc();
    #1 chk("op_start_last", add_start, 1'b1);
    chk("op_done_last", add_done, 1'b1);
    cyc();
    #1 chk("op_rsp_valid", bus.rsp_valid, oh);
    chk("op_rsp_data", bus.rsp_data, exp_data);
    cyc();
    #1 chk("op_idle_after", add_start, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_acc, last_acc, acc_r, cyc_n, pulses;
    logic [NREQ-1:0] acc;
    logic [NREQ-1:0] g_hist [8];
    int ix;

    bus.req_valid  = '0;
    bus1.req_valid = '0;
    for (int r = 0; r < NREQ; r++) begin
      bus.req_op[r]  = ALU_ADD;
      bus.req_a[r]   = '0;
      bus.req_b[r]   = '0;
      bus1.req_op[r] = ALU_ADD;
      bus1.req_a[r]  = '0;
      bus1.req_b[r]  = '0;
    end

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", bus.req_ready, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_add_start", add_start, 1'b0);
    chk("rst_add_op", add_op, ALU_ADD);
    chk("rst_add_a", add_a, 32'h0);
    chk("rst_add_b", add_b, 32'h0);
    chk("rst_state", dbg_state, ARB_IDLE);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Single ADD then subtract path
    single_op(0, ALU_ADD, 32'h0000FFFF, 32'h1, 32'h00010000);
    single_op(1, ALU_LT, 32'd5, 32'd7, 32'hFFFFFFFE);

    // Contention: both requesters continuously valid
    for (int r = 0; r < NREQ; r++) begin
      bus.req_op[r] = ALUOp_t'($urandom_range(0, 3));
      bus.req_a[r]  = $urandom;
      bus.req_b[r]  = $urandom;
    end
    bus.req_valid = 2'b11;
    n_acc = 0; last_acc = 0; cyc_n = 0; acc_r = 0;
    while (n_acc < 8 && cyc_n < 40) begin
      #1;
      acc = bus.req_valid & bus.req_ready;
      for (int r = 0; r < NREQ; r++) begin
        if (acc[r]) begin
          chk("cont_grant", r, n_acc % 2);
          if (n_acc > 0) begin
            chk("cont_gap", cyc_n - last_acc, NCYC);
            chk("cont_in_done", add_done, 1'b1);
          end
          last_acc = cyc_n;
          acc_r = r;
          n_acc++;
        end
      end
      cyc();
      if (acc != '0) begin
        bus.req_op[acc_r] = ALUOp_t'($urandom_range(0, 3));
        bus.req_a[acc_r]  = $urandom;
        bus.req_b[acc_r]  = $urandom;
      end
      if (n_acc == 8) bus.req_valid = '0;
      cyc_n++;
    end
    bus.req_valid = '0;
    chk("cont_count", n_acc, 8);
    repeat (4) cyc();

    // Flush: blocks grants in idle, suppresses an in-flight response
    bus.req_op[0] = ALU_ADD;
    bus.req_a[0]  = 32'hDEAD0000;
    bus.req_b[0]  = 32'h0000BEEF;
    bus.req_valid = 2'b01;
    flush = 1'b1;
    #1 chk("flush_idle_block", bus.req_ready, 2'b00);
    flush = 1'b0;
    #1 chk("flush_idle_release", bus.req_ready, 2'b01);
    cyc();
    bus.req_valid = '0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1 chk("flush_adder_done", add_done, 1'b1);
    pulses = 0;
    repeat (3) begin
      cyc();
      if (bus.rsp_valid != '0) pulses++;
    end
    chk("flush_no_rsp", pulses, 0);
    single_op(1, ALU_ADD, 32'h12345678, 32'h11111111, 32'h23456789);

    // Flush in the done cycle: result dropped, no grant that cycle
    bus.req_a[0] = 32'h00000100;
    bus.req_b[0] = 32'h00000001;
    bus.req_valid = 2'b01;
    cyc();
    bus.req_valid = '0;
    cyc();
    flush = 1'b1;
    bus.req_a[1] = 32'h00000040;
    bus.req_b[1] = 32'h00000002;
    bus.req_op[1] = ALU_SUB;
    bus.req_valid = 2'b10;
    #1 chk("flushdone_done", add_done, 1'b1);
    chk("flushdone_block", bus.req_ready, 2'b00);
    cyc();
    flush = 1'b0;
    #1 chk("flushdone_no_rsp", bus.rsp_valid, 2'b00);
    chk("flushdone_next_grant", bus.req_ready, 2'b10);
    cyc();
    bus.req_valid = '0;
    repeat (5) cyc();

    // Reset in the middle of an operation
    bus.req_a[0] = 32'h0F0F0F0F;
    bus.req_b[0] = 32'h01010101;
    bus.req_op[0] = ALU_ADD;
    bus.req_valid = 2'b11;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_start", add_start, 1'b0);
    chk("midrst_state", dbg_state, ARB_IDLE);
    chk("midrst_ready", bus.req_ready, 2'b00);
    chk("midrst_rsp", bus.rsp_valid, 2'b00);
    chk("midrst_add_a", add_a, 32'h0);
    repeat (2) cyc();
    rst_n = 1'b1;
    #1 chk("midrst_first_grant", bus.req_ready, 2'b01);
    cyc();
    bus.req_valid = '0;
    repeat (4) cyc();

    // Random traffic with occasional flush
    for (int c = 0; c < 300; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!bus.req_valid[r] && $urandom_range(0, 2) == 0) begin
          bus.req_op[r]    = ALUOp_t'($urandom_range(0, 3));
          bus.req_a[r]     = $urandom;
          bus.req_b[r]     = $urandom;
          bus.req_valid[r] = 1'b1;
        end
      end
      flush = ($urandom_range(0, 15) == 0);
      #1 acc = bus.req_valid & bus.req_ready;
      cyc();
      bus.req_valid = bus.req_valid & ~acc;
    end
    flush = 1'b0;
    bus.req_valid = '0;
    repeat (6) cyc();

    // Single-slice instance: latency 2, one accept per cycle
    for (int r = 0; r < NREQ; r++) begin
      bus1.req_op[r] = ALU_ADD;
      bus1.req_a[r]  = 32'(100 * (r + 1));
      bus1.req_b[r]  = 32'(r + 3);
    end
    bus1.req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1;
      g_hist[k] = bus1.req_ready;
      chk("ss_grant", g_hist[k], (k % 2 == 1) ? 2'b10 : 2'b01);
      if (k >= 1) chk("ss_start", add1_start, 1'b1);
      if (k >= 2) begin
        ix = (k - 2) % 2;
        chk("ss_rsp_tag", bus1.rsp_valid, g_hist[k-2]);
        chk("ss_rsp_data", bus1.rsp_data, 32'(100 * (ix + 1) + ix + 3));
      end
      cyc();
    end
    bus1.req_valid = '0;
    repeat (6) cyc();

    chk("sb_drained", exp_q.size(), 0);
    chk("sb_no_pending", pend, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
